// File: rtl/soc_arb_bb.sv
// soc_arb_bb: round-robin arbiter for the shared Blackbone bus.
// Issues a one-hot grant plus index, bounds each tenure to MAX_BEATS cycles,
// and parks the bus for an external agent through bus_hold / bus_hold_ack.
module soc_arb_bb #(
  parameter  int unsigned MASTERS   = 2,
  parameter  int unsigned MAX_BEATS = 8,
  localparam int unsigned IDX_WIDTH = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MASTERS-1:0]   m_req_i,
  output logic [MASTERS-1:0]   m_gnt_o,
  output logic [IDX_WIDTH-1:0] gnt_idx_o,
  output logic                 bus_active_o,
  input  logic                 bus_hold,
  output logic                 bus_hold_ack
);

  localparam int unsigned CNT_W    = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned CNT_LAST = (MAX_BEATS == 0) ? 0 : MAX_BEATS - 1;
  localparam logic [CNT_W-1:0] CNT_LAST_V = CNT_W'(CNT_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD
  } state_t;

  state_t               state_q;
  logic [IDX_WIDTH-1:0] ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [IDX_WIDTH-1:0] next_ptr_c;
  logic [IDX_WIDTH-1:0] base_c;
  logic                 pick_vld_c;
  logic [IDX_WIDTH-1:0] pick_idx_c;
  logic                 tenure_end_c;
  logic                 release_c;

  // Round-robin pick; while granted, scan from the slot after the owner so the
  // rotated pointer already applies to a back-to-back handover.
  always_comb begin
    logic [IDX_WIDTH-1:0] j;
    next_ptr_c = IDX_WIDTH'((32'(gnt_idx_o) + 32'd1) % MASTERS);
    base_c     = (state_q == S_GRANT) ? next_ptr_c : ptr_q;
    pick_vld_c = 1'b0;
    pick_idx_c = '0;
    j          = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      j = IDX_WIDTH'((32'(base_c) + i) % MASTERS);
      if (!pick_vld_c && m_req_i[j]) begin
        pick_vld_c = 1'b1;
        pick_idx_c = j;
      end
    end
  end

  // Tenure end: owner drops its request, beat budget spent, or bus park requested.
  always_comb begin
    tenure_end_c = (MAX_BEATS != 0) && (cnt_q == CNT_LAST_V);
    release_c    = !m_req_i[gnt_idx_o] || tenure_end_c || bus_hold;
  end

  // Arbitration FSM with registered grant, index and hold acknowledge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      m_gnt_o      <= '0;
      gnt_idx_o    <= '0;
      bus_active_o <= 1'b0;
      bus_hold_ack <= 1'b0;
    end else begin
      // Ack trails HOLD by one edge so it never overlaps an active grant.
      bus_hold_ack <= (state_q == S_HOLD);
      case (state_q)
        S_IDLE: begin
          if (bus_hold) begin
            state_q <= S_HOLD;
          end else if (pick_vld_c && !bus_hold_ack) begin
            state_q      <= S_GRANT;
            m_gnt_o      <= MASTERS'(1) << pick_idx_c;
            gnt_idx_o    <= pick_idx_c;
            bus_active_o <= 1'b1;
            cnt_q        <= '0;
          end
        end
        S_GRANT: begin
          if (cnt_q != CNT_LAST_V) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (release_c) begin
            ptr_q        <= next_ptr_c;
            m_gnt_o      <= '0;
            bus_active_o <= 1'b0;
            if (bus_hold) begin
              state_q <= S_HOLD;
            end else if (pick_vld_c && (MASTERS > 1)) begin
              state_q      <= S_GRANT;
              m_gnt_o      <= MASTERS'(1) << pick_idx_c;
              gnt_idx_o    <= pick_idx_c;
              bus_active_o <= 1'b1;
              cnt_q        <= '0;
            end else begin
              // A lone master still gets one released cycle between tenures.
              state_q <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (!bus_hold) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_arb_bb.sv
// Directed bench for soc_arb_bb: a 4-master limited instance and a 4-master
// unlimited instance, checked cycle by cycle against a queue of expectations.
module tb_soc_arb_bb;

  logic       clk;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic       hold_a, hold_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       act_a, act_b;
  logic       ack_a, ack_b;

  soc_arb_bb #(.MASTERS(4), .MAX_BEATS(8)) dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .m_req_i      (req_a),
    .m_gnt_o      (gnt_a),
    .gnt_idx_o    (idx_a),
    .bus_active_o (act_a),
    .bus_hold     (hold_a),
    .bus_hold_ack (ack_a)
  );

  soc_arb_bb #(.MASTERS(4), .MAX_BEATS(0)) dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .m_req_i      (req_b),
    .m_gnt_o      (gnt_b),
    .gnt_idx_o    (idx_b),
    .bus_active_o (act_b),
    .bus_hold     (hold_b),
    .bus_hold_ack (ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         inst;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       ack;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  function automatic logic [3:0] oh(input int m);
    return 4'(1 << m);
  endfunction

  task automatic push(input bit inst, input logic [3:0] g, input logic [1:0] i,
                      input logic k, input string tag);
    exp_t e;
    e.inst = inst;
    e.gnt  = g;
    e.idx  = i;
    e.ack  = k;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [3:0] og;
    logic [1:0] oi;
    logic       oa, ok;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e  = sb.pop_front();
    og = e.inst ? gnt_b : gnt_a;
    oi = e.inst ? idx_b : idx_a;
    oa = e.inst ? act_b : act_a;
    ok = e.inst ? ack_b : ack_a;
    assert (og === e.gnt) else begin
      failures++;
      $error("FAIL %s gnt observed=%b expected=%b", e.tag, og, e.gnt);
    end
    checks++;
    assert (oi === e.idx) else begin
      failures++;
      $error("FAIL %s idx observed=%0d expected=%0d", e.tag, oi, e.idx);
    end
    checks++;
    assert (oa === (|e.gnt)) else begin
      failures++;
      $error("FAIL %s active observed=%b expected=%b", e.tag, oa, |e.gnt);
    end
    checks++;
    assert (ok === e.ack) else begin
      failures++;
      $error("FAIL %s ack observed=%b expected=%b", e.tag, ok, e.ack);
    end
  endtask

  task automatic cyc(input bit inst, input logic [3:0] g, input logic [1:0] i,
                     input logic k, input string tag);
    push(inst, g, i, k, tag);
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    req_a    = '0;
    req_b    = '0;
    hold_a   = 1'b0;
    hold_b   = 1'b0;

    // Reset values on both instances
    #2 rst = 1'b1;
    #1;
    push(1'b0, 4'b0000, 2'd0, 1'b0, "rst_a");
    check_now();
    push(1'b1, 4'b0000, 2'd0, 1'b0, "rst_b");
    check_now();
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "rst_held0");
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "rst_held1");

    // First grant after reset goes to m0
    rst   = 1'b0;
    req_a = 4'b0011;
    cyc(1'b0, oh(0), 2'd0, 1'b0, "first_gnt_m0");
    cyc(1'b0, oh(0), 2'd0, 1'b0, "first_gnt_m0_b2");

    // Asynchronous reset while granted
    rst = 1'b1;
    #1;
    push(1'b0, 4'b0000, 2'd0, 1'b0, "rst_async");
    check_now();
    req_a = 4'b1111;
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "rst_async_held");
    rst = 1'b0;

    // Fairness: 8-beat tenures rotating 0,1,2,3,0 with no gap
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, oh((k / 8) % 4), 2'((k / 8) % 4), 1'b0, $sformatf("fair_c%0d", k));
    end
    req_a = 4'b0000;
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "fair_release");

    // Early release of m1, then pointer at 2 picks m2 over m0
    req_a = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, oh(1), 2'd1, 1'b0, $sformatf("early_m1_%0d", k));
    end
    req_a = 4'b0000;
    cyc(1'b0, 4'b0000, 2'd1, 1'b0, "early_idle");
    req_a = 4'b0101;
    cyc(1'b0, oh(2), 2'd2, 1'b0, "ptr2_pick_m2");
    req_a = 4'b0000;
    cyc(1'b0, 4'b0000, 2'd2, 1'b0, "m2_release");

    // Hold during m0's second beat with m1 pending
    req_a = 4'b0001;
    cyc(1'b0, oh(0), 2'd0, 1'b0, "hold_m0_b1");
    req_a = 4'b0011;
    cyc(1'b0, oh(0), 2'd0, 1'b0, "hold_m0_b2");
    hold_a = 1'b1;
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "hold_enter");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'b0000, 2'd0, 1'b1, $sformatf("hold_ack_%0d", k));
    end
    hold_a = 1'b0;
    cyc(1'b0, 4'b0000, 2'd0, 1'b1, "hold_exit_idle");
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "hold_ack_drop");
    cyc(1'b0, oh(1), 2'd1, 1'b0, "hold_pending_m1");
    req_a = 4'b0000;
    cyc(1'b0, 4'b0000, 2'd1, 1'b0, "m1_release");

    // Hold and request rise together in IDLE: hold wins
    hold_a = 1'b1;
    req_a  = 4'b0001;
    cyc(1'b0, 4'b0000, 2'd1, 1'b0, "hold_vs_req");
    cyc(1'b0, 4'b0000, 2'd1, 1'b1, "hold_vs_req_ack");
    hold_a = 1'b0;
    cyc(1'b0, 4'b0000, 2'd1, 1'b1, "hvr_exit_idle");
    cyc(1'b0, 4'b0000, 2'd1, 1'b0, "hvr_ack_drop");
    cyc(1'b0, oh(0), 2'd0, 1'b0, "hvr_gnt_m0");

    // Unknown requests from non-owners leave the grant alone
    req_a = 4'bxxx1;
    cyc(1'b0, oh(0), 2'd0, 1'b0, "x_nonowner");
    req_a = 4'b0000;
    cyc(1'b0, 4'b0000, 2'd0, 1'b0, "x_release");

    // Unlimited tenure: m0 keeps the bus for 100 cycles while m1 waits
    req_b = 4'b0011;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, oh(0), 2'd0, 1'b0, $sformatf("unl_m0_%0d", k));
    end
    req_b = 4'b0010;
    cyc(1'b1, oh(1), 2'd1, 1'b0, "unl_m1");
    req_b = 4'b0000;
    cyc(1'b1, 4'b0000, 2'd1, 1'b0, "unl_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
